// File: rtl/key_pkg.sv
// Shared types and default constants for the multi-channel key conditioner.
// Default counts assume a 50 MHz system clock.
package key_pkg;

  typedef enum logic [1:0] {
    KEY_IDLE,
    KEY_PRESS_DB,
    KEY_HELD,
    KEY_RELEASE_DB
  } key_state_t;

  localparam int KEY_NUM_DEF        = 4;
  localparam int DB_CNT_MAX_DEF     = 999_999;
  localparam int LONG_CNT_MAX_DEF   = 49_999_999;
  localparam int REPEAT_CNT_MAX_DEF = 9_999_999;

  // Counter width able to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_chan.sv
// One key channel: 2-flop synchroniser, debounce FSM, hold and repeat counters.
// Optional auto-repeat is built only when KEY_REPEAT_EN is defined.
module key_chan
  import key_pkg::*;
#(
  parameter int DB_CNT_MAX     = DB_CNT_MAX_DEF,
  parameter int LONG_CNT_MAX   = LONG_CNT_MAX_DEF,
  parameter int REPEAT_CNT_MAX = REPEAT_CNT_MAX_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_repeat
);

  localparam int DB_W   = cnt_width(DB_CNT_MAX);
  localparam int HOLD_W = cnt_width(LONG_CNT_MAX);

  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DB_CNT_MAX);
  localparam logic [HOLD_W-1:0] LONG_MAX = HOLD_W'(LONG_CNT_MAX);

  logic [1:0]        sync_q, sync_d;
  logic              key_s;
  key_state_t        state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              long_done_q, long_done_d;
  logic              key_level_q, key_level_d;
  logic              key_press_q, key_press_d;
  logic              key_release_q, key_release_d;
  logic              key_long_q, key_long_d;
  logic              key_repeat_q, key_repeat_d;

  assign key_s = sync_q[1];

  always_comb begin
    sync_d        = {sync_q[0], key_in};
    state_d       = state_q;
    db_cnt_d      = db_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    long_done_d   = long_done_q;
    key_press_d   = 1'b0;
    key_release_d = 1'b0;
    key_long_d    = 1'b0;

    case (state_q)
      KEY_IDLE: begin
        if (!key_s) begin
          state_d  = KEY_PRESS_DB;
          db_cnt_d = '0;
        end
      end
      KEY_PRESS_DB: begin
        if (key_s) begin
          state_d = KEY_IDLE;
        end else if (db_cnt_q == DB_MAX) begin
          state_d     = KEY_HELD;
          key_press_d = 1'b1;
          hold_cnt_d  = '0;
          long_done_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      KEY_HELD: begin
        // Counting continues on the leaving edge; only the pulses are suppressed there.
        if (hold_cnt_q != LONG_MAX) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
        if (key_s) begin
          state_d  = KEY_RELEASE_DB;
          db_cnt_d = '0;
        end else if ((hold_cnt_q == LONG_MAX) && !long_done_q) begin
          key_long_d  = 1'b1;
          long_done_d = 1'b1;
        end
      end
      KEY_RELEASE_DB: begin
        if (!key_s) begin
          state_d = KEY_HELD;
        end else if (db_cnt_q == DB_MAX) begin
          state_d       = KEY_IDLE;
          key_release_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: state_d = KEY_IDLE;
    endcase

    key_level_d = (state_d == KEY_HELD) || (state_d == KEY_RELEASE_DB);
  end

`ifdef KEY_REPEAT_EN
  localparam int REP_W = cnt_width(REPEAT_CNT_MAX);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CNT_MAX);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

  // Repeat period starts at the long pulse and saturates while a release is pending.
  always_comb begin
    rep_cnt_d    = rep_cnt_q;
    key_repeat_d = 1'b0;
    if (key_long_d) begin
      rep_cnt_d = '0;
    end else if ((state_q == KEY_HELD) && long_done_q) begin
      if (rep_cnt_q != REP_MAX) begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end else if (!key_s) begin
        key_repeat_d = 1'b1;
        rep_cnt_d    = '0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end
`else
  assign key_repeat_d = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sync_q        <= 2'b11;
      state_q       <= KEY_IDLE;
      db_cnt_q      <= '0;
      hold_cnt_q    <= '0;
      long_done_q   <= 1'b0;
      key_level_q   <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
      key_long_q    <= 1'b0;
      key_repeat_q  <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      state_q       <= state_d;
      db_cnt_q      <= db_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      long_done_q   <= long_done_d;
      key_level_q   <= key_level_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      key_long_q    <= key_long_d;
      key_repeat_q  <= key_repeat_d;
    end
  end

  assign key_level   = key_level_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;
  assign key_long    = key_long_q;
  assign key_repeat  = key_repeat_q;

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-channel push-button conditioner: KEY_NUM independent key_chan instances.
// Define KEY_REPEAT_EN to build the auto-repeat counters.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int KEY_NUM        = KEY_NUM_DEF,
  parameter int DB_CNT_MAX     = DB_CNT_MAX_DEF,
  parameter int LONG_CNT_MAX   = LONG_CNT_MAX_DEF,
  parameter int REPEAT_CNT_MAX = REPEAT_CNT_MAX_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] key_repeat
);

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_chan
    key_chan #(
      .DB_CNT_MAX    (DB_CNT_MAX),
      .LONG_CNT_MAX  (LONG_CNT_MAX),
      .REPEAT_CNT_MAX(REPEAT_CNT_MAX)
    ) u_chan (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .key_in     (key_in[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i]),
      .key_repeat (key_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed testbench for key_debounce_multi with short simulation counts.
// Expected edges are hand-computed from the first low sample of each scenario.
module tb_key_debounce_multi;

  localparam int KEY_NUM = 4;
  localparam int DB      = 999;
  localparam int LONG    = 4999;
  localparam int REP     = 999;

  logic               sys_clk = 1'b0;
  logic               sys_rst_n;
  logic [KEY_NUM-1:0] key_in;
  logic [KEY_NUM-1:0] key_level, key_press, key_release, key_long, key_repeat;

  int checks   = 0;
  int failures = 0;

  int press_n[KEY_NUM], press_at[KEY_NUM], press_last[KEY_NUM];
  int release_n[KEY_NUM], release_at[KEY_NUM];
  int long_n[KEY_NUM], long_at[KEY_NUM];
  int rep_n[KEY_NUM], rep_at0[KEY_NUM], rep_at1[KEY_NUM];
  int rise_at[KEY_NUM], fall_at[KEY_NUM], fall_n[KEY_NUM];
  int any_out[KEY_NUM];
  logic prev_level[KEY_NUM];
  int both12_at;
  int snap_idx;
  logic [5*KEY_NUM-1:0] snap;

  always #5 sys_clk = ~sys_clk;

  key_debounce_multi #(
    .KEY_NUM       (KEY_NUM),
    .DB_CNT_MAX    (DB),
    .LONG_CNT_MAX  (LONG),
    .REPEAT_CNT_MAX(REP)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .key_repeat (key_repeat)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Raw key pattern per scenario at edge k (1 = released).
  function automatic logic [KEY_NUM-1:0] keyPattern(input int scn, input int k);
    logic [KEY_NUM-1:0] v;
    v = '1;
    case (scn)
      0: v[0] = (k >= 2000);
      1: v[1] = (k < 100) ? (((k * 7) % 5) >= 2) : (k >= 3100);
      2: v[2] = (k >= 500);
      3: v[3] = (k >= 8500);
      4: v[0] = !((k < 2000) || ((k >= 2300) && (k < 7000)));
      5: begin
        v[1] = (k >= 3000);
        v[2] = (k >= 3000);
      end
      default: v = '1;
    endcase
    return v;
  endfunction

  function automatic logic rstPattern(input int scn, input int k);
    return !((scn == 5) && (k >= 1500) && (k <= 1502));
  endfunction

  task automatic clearRecords();
    for (int c = 0; c < KEY_NUM; c++) begin
      press_n[c] = 0;   press_at[c] = -1;   press_last[c] = -1;
      release_n[c] = 0; release_at[c] = -1;
      long_n[c] = 0;    long_at[c] = -1;
      rep_n[c] = 0;     rep_at0[c] = -1;    rep_at1[c] = -1;
      rise_at[c] = -1;  fall_at[c] = -1;    fall_n[c] = 0;
      any_out[c] = 0;   prev_level[c] = key_level[c];
    end
    both12_at = -1;
    snap      = '1;
  endtask

  task automatic applyStimulus(input int scn, input int n_cycles);
    clearRecords();
    for (int k = 0; k < n_cycles; k++) begin
      @(negedge sys_clk);
      key_in    = keyPattern(scn, k);
      sys_rst_n = rstPattern(scn, k);
      @(posedge sys_clk);
      #1;
      for (int c = 0; c < KEY_NUM; c++) begin
        if (key_press[c]) begin
          if (press_n[c] == 0) press_at[c] = k;
          press_last[c] = k;
          press_n[c]++;
        end
        if (key_release[c]) begin
          if (release_n[c] == 0) release_at[c] = k;
          release_n[c]++;
        end
        if (key_long[c]) begin
          if (long_n[c] == 0) long_at[c] = k;
          long_n[c]++;
        end
        if (key_repeat[c]) begin
          if (rep_n[c] == 0) rep_at0[c] = k;
          if (rep_n[c] == 1) rep_at1[c] = k;
          rep_n[c]++;
        end
        if (key_level[c] && !prev_level[c] && (rise_at[c] < 0)) rise_at[c] = k;
        if (!key_level[c] && prev_level[c]) begin
          if (fall_n[c] == 0) fall_at[c] = k;
          fall_n[c]++;
        end
        prev_level[c] = key_level[c];
        if (key_level[c] | key_press[c] | key_release[c] | key_long[c] | key_repeat[c]) any_out[c] = 1;
      end
      if ((key_press[2:1] == 2'b11) && (both12_at < 0)) both12_at = k;
      if (k == snap_idx) snap = {key_level, key_press, key_release, key_long, key_repeat};
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    key_in    = '1;
    snap_idx  = -1;
    repeat (3) @(posedge sys_clk);
    #1;
    checkOutput("reset_state", 32'({key_level, key_press, key_release, key_long, key_repeat}), 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (5) @(posedge sys_clk);

    applyStimulus(0, 3200);
    checkOutput("clean_press_at", press_at[0], 1002);
    checkOutput("clean_press_n", press_n[0], 1);
    checkOutput("clean_level_rise", rise_at[0], 1002);
    checkOutput("clean_level_fall", fall_at[0], 3002);
    checkOutput("clean_release_at", release_at[0], 3002);
    checkOutput("clean_release_n", release_n[0], 1);
    checkOutput("clean_no_long", long_n[0], 0);

    applyStimulus(1, 4300);
    checkOutput("bounce_press_n", press_n[1], 1);
    checkOutput("bounce_press_at", press_at[1], 1102);
    checkOutput("bounce_release_n", release_n[1], 1);
    checkOutput("bounce_release_at", release_at[1], 4102);
    checkOutput("bounce_fall_n", fall_n[1], 1);

    applyStimulus(2, 1200);
    checkOutput("glitch_quiet", any_out[2], 0);

    applyStimulus(3, 9700);
    checkOutput("long_press_at", press_at[3], 1002);
    checkOutput("long_long_at", long_at[3], 6002);
    checkOutput("long_long_n", long_n[3], 1);
`ifdef KEY_REPEAT_EN
    checkOutput("long_rep_n", rep_n[3], 2);
    checkOutput("long_rep_at0", rep_at0[3], 7002);
    checkOutput("long_rep_at1", rep_at1[3], 8002);
`else
    checkOutput("long_rep_n", rep_n[3], 0);
`endif
    checkOutput("long_release_at", release_at[3], 9502);

    applyStimulus(4, 8200);
    checkOutput("rbounce_release_n", release_n[0], 1);
    checkOutput("rbounce_release_at", release_at[0], 8002);
    checkOutput("rbounce_fall_n", fall_n[0], 1);
    checkOutput("rbounce_long_at", long_at[0], 6302);
    checkOutput("rbounce_rep_n", rep_n[0], 0);

    snap_idx = 1500;
    applyStimulus(5, 4200);
    checkOutput("simul_press1_at", press_at[1], 1002);
    checkOutput("simul_press2_at", press_at[2], 1002);
    checkOutput("simul_both_at", both12_at, 1002);
    checkOutput("reset_mid_outputs", 32'(snap), 32'd0);
    checkOutput("reset_press1_n", press_n[1], 2);
    checkOutput("reset_press1_last", press_last[1], 2505);
    checkOutput("reset_press2_last", press_last[2], 2505);
    checkOutput("reset_release2_at", release_at[2], 4002);
    checkOutput("reset_ch0_quiet", any_out[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
